sub_bytes_iterative: RTL
========================

Name: sub_bytes_iterative

Overview:
Area-reduced, multi-cycle SubBytes / InvSubBytes engine for the iterative AES datapath. It accepts a 128-bit state with a direction bit and substitutes BYTES_PER_CYCLE bytes per clock through shared S-box lanes. It returns the substituted state over a valid/ready handshake. Results must match the combinational SubBytes / SubBytesInverse blocks bit for bit.

Parameters:
BYTES_PER_CYCLE, 4, number of S-box lanes. Legal values are 1, 2, 4, 8 and 16; elaboration fails for any other value.
NUM_STEPS, 16/BYTES_PER_CYCLE, derived localparam; number of substitution cycles per state.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream offers a state
in_ready  output  1  engine can accept a state (high only in IDLE)
decrypt  input  1  0 = SubBytes, 1 = InvSubBytes; sampled at accept
in_state  input  128  state_t; byte 0 = bits [127:120] (FIPS-197 order)
out_valid  output  1  out_state holds a finished result
out_ready  input  1  downstream accepts the result
out_state  output  128  substituted state_t
busy  output  1  high in RUN and DONE

Behaviour:
- Reset values: in_ready=1 once out of reset, out_valid=0, out_state=0, busy=0, internal step counter=0, mode=0, FSM=IDLE. Reset asserted mid-operation aborts the state immediately; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a clock edge, capture in_state into the working register, capture decrypt into mode, set step=0 and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, bytes [step*BPC .. step*BPC+BPC-1] of the working register are replaced by S(byte) or InvS(byte), selected by mode.
  - step increments each cycle. When step==NUM_STEPS-1, that cycle's substitution completes and the next state is DONE.
- DONE:
  - out_valid=1 and out_state = working register; both held stable until out_ready=1.
  - On an edge with out_ready=1, go to IDLE with out_valid=0. out_state keeps its last value.
- Latency and throughput:
  - The accept edge is T. out_valid rises at edge T+NUM_STEPS (T+4 at the default).
  - Minimum spacing between accepts is NUM_STEPS+2 cycles. There is no back-to-back accept from DONE.
- Handshake rules:
  - in_valid and in_state are ignored outside IDLE.
  - decrypt changes after accept have no effect on the state in flight.
  - out_ready while not in DONE is ignored.
  - in_ready must not depend combinationally on in_valid or out_ready.
- Width rules: the step counter is $clog2(NUM_STEPS) bits, minimum 1. When NUM_STEPS=1, RUN lasts exactly one cycle.
- No X propagation: unused working-register bytes retain their prior values.

Decomposition:
- Shared package AESDefinitions holds:
  - state_t (128-bit)
  - byte_t
  - the forward and inverse S-box constant tables, shared with SubBytes and SubBytesInverse so all three blocks use a single source of truth.
- One sub-module, sbox_lane: combinational, 8-bit in, 8-bit out, plus a decrypt select; it looks up the forward or inverse table. sub_bytes_iterative instantiates BYTES_PER_CYCLE lanes in a generate loop and muxes them onto the working register by step.
- The bench reuses the existing AESTestDefinitions and UnitTester, with the "s_box" vector set.

Test Plan:
1. Forward FIPS-197 App. B: accept 193de3bea0f4e22b9ac68d2ae9f84808 with decrypt=0 and out_ready=1. Required: out_state = d42711aee0bf98f1b8b45de51e415230, with out_valid rising exactly 4 cycles after the accept edge.
2. Inverse: input d42711aee0bf98f1b8b45de51e415230 with decrypt=1 must return 193de3bea0f4e22b9ac68d2ae9f84808. An all-0x63 state must return all-0x00.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_state stays stable, in_ready=0 and busy=1 throughout, and a new in_valid offered during this time is not accepted. After out_ready pulses, return to IDLE within 1 cycle.
4. Mode capture: accept with decrypt=0, then toggle decrypt every cycle while in RUN. Required: the result equals the forward result, e.g. 00..00 -> 6363..63.
5. Reset mid-RUN: assert reset at step 2. Required: out_valid=0 and in_ready=1 once reset is released, and no result appears. The next accept, 5353..53 with decrypt=0, yields eded..ed.
6. Parameter sweep: rebuild with BYTES_PER_CYCLE=1 and 16. Repeat scenario 1 and check latencies of 16 and 1 cycles respectively. Then run the full s_box vector file in both directions against SubBytes / SubBytesInverse.

Source files
------------

// File: rtl/sub_bytes_iterative_pkg.sv
// Shared AES definitions for the iterative SubBytes engine.
//   - state_t / byte_t : 128-bit AES state and single byte types
//   - state_e          : engine FSM encoding
//   - SBOX_FWD_TBL / SBOX_INV_TBL : forward and inverse S-box constants,
//     entry 0 in the top byte of each table
//   - sbox_fwd() / sbox_inv()     : table lookups
package sub_bytes_iterative_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2047:0] SBOX_FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry i sits at bits [(255-i)*8 +: 8]; ~b == 255-b for a byte.
    function automatic byte_t sbox_fwd(input byte_t b);
        return SBOX_FWD_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic byte_t sbox_inv(input byte_t b);
        return SBOX_INV_TBL[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sub_bytes_iterative_sbox_lane.sv
// sbox_lane: one combinational S-box lane.
//   in_byte  : byte to substitute
//   decrypt  : 0 = forward S-box, 1 = inverse S-box
//   out_byte : substituted byte
module sbox_lane
    import sub_bytes_iterative_pkg::*;
(
    input  logic  [7:0] in_byte,
    input  logic        decrypt,
    output logic  [7:0] out_byte
);

    always_comb begin
        out_byte = decrypt ? sbox_inv(in_byte) : sbox_fwd(in_byte);
    end

endmodule

// File: rtl/sub_bytes_iterative.sv
// sub_bytes_iterative: multi-cycle SubBytes / InvSubBytes engine.
// BYTES_PER_CYCLE shared S-box lanes walk the 16 state bytes over
// NUM_STEPS cycles; the result is held on a valid/ready output.
//   clock, reset          : rising-edge clock, async active-high reset
//   in_valid / in_ready   : input handshake (in_ready high only in IDLE)
//   decrypt               : direction, captured at accept
//   in_state              : input state, byte 0 in bits [127:120]
//   out_valid / out_ready : output handshake
//   out_state             : substituted state
//   busy                  : high while in RUN or DONE
module sub_bytes_iterative
    import sub_bytes_iterative_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
        $error("sub_bytes_iterative: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_e               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 mode_q, mode_d;
    // Element 15 holds state byte 0 so the packed vector matches state_t order.
    logic [15:0][7:0]     work_q, work_d;
    logic [15:0][7:0]     work_sub;
    state_t               out_state_q, out_state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [BYTES_PER_CYCLE-1:0][7:0] lane_in;
    logic [BYTES_PER_CYCLE-1:0][7:0] lane_out;

    // Packed-array slot of the byte handled by lane l in the current step.
    function automatic logic [3:0] lane_slot(input logic [STEP_W-1:0] s, input int l);
        logic [3:0] pos;
        pos = 4'(int'(s) * BYTES_PER_CYCLE + l);
        return ~pos;
    endfunction

    always_comb begin
        lane_in = '0;
        for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
            lane_in[l] = work_q[lane_slot(step_q, l)];
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        sbox_lane u_lane (
            .in_byte  (lane_in[g]),
            .decrypt  (mode_q),
            .out_byte (lane_out[g])
        );
    end

    // Bytes outside the current window pass through untouched.
    always_comb begin
        work_sub = work_q;
        for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
            work_sub[lane_slot(step_q, l)] = lane_out[l];
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        mode_d      = mode_q;
        work_d      = work_q;
        out_state_d = out_state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    mode_d  = decrypt;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = work_sub;
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    step_d      = '0;
                    out_state_d = work_sub;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are decoded from the next state so they come straight off flops.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            mode_q      <= 1'b0;
            work_q      <= '0;
            out_state_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            work_q      <= work_d;
            out_state_q <= out_state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule
